// File: rtl/fb_scanout_if.sv
// Framebuffer read port plus VGA output bundle used by fb_scanout.
interface fb_scanout_if;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output rd_addr, rd_en, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
    input  rd_data
  );

  modport slave (
    input  rd_addr, rd_en, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
    output rd_data
  );
endinterface

// File: rtl/fb_scanout.sv
// VGA scan-out of the waveform framebuffer into a fixed screen window (black elsewhere).
// Build option SCALE2X_EN: show each framebuffer pixel as a 2x2 block at the same window origin.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 300,
  parameter int FB_H     = 200,
  parameter int X_OFF    = 20,
  parameter int Y_OFF    = 40,
  parameter int RD_LAT   = 2
) (
  input logic          DCLK,
  input logic          RESET,
  fb_scanout_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LAT     = RD_LAT + 2;
`ifdef SCALE2X_EN
  localparam int SCALE   = 2;
`else
  localparam int SCALE   = 1;
`endif
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(FB_W);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] X_LO     = HW'(X_OFF);
  localparam logic [HW-1:0] X_HI     = HW'(X_OFF + SCALE * FB_W);
  localparam logic [HW-1:0] X_LAST   = HW'(X_OFF + SCALE * FB_W - 1);
  localparam logic [VW-1:0] Y_LO     = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_HI     = VW'(Y_OFF + SCALE * FB_H);

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic           hs_p0, vs_p0, act_p0, vld_p0, sof_p0;
  logic           last_col_p0, col_step_p0, row_step_p0;
  logic [15:0]    row_base;
  logic [CW-1:0]  col;
  logic [LAT:1]   hs_sr, vs_sr, sof_sr;
  logic [LAT-1:1] act_sr, vld_sr;
  logic [3:0]     rd_data_unused;

  assign rd_data_unused = bus.rd_data[15:12];

  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // ---- p0: decode of the current screen position ----
  always_comb begin
    hs_p0       = !(h_cnt >= HS_START && h_cnt < HS_END);
    vs_p0       = !(v_cnt >= VS_START && v_cnt < VS_END);
    act_p0      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    vld_p0      = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
    sof_p0      = (h_cnt == '0) && (v_cnt == '0);
    last_col_p0 = (h_cnt == X_LAST);
`ifdef SCALE2X_EN
    // Odd offset from the window edge marks the second copy of a pixel / line.
    col_step_p0 = h_cnt[0] ^ X_LO[0];
    row_step_p0 = v_cnt[0] ^ Y_LO[0];
`else
    col_step_p0 = 1'b1;
    row_step_p0 = 1'b1;
`endif
  end

  // ---- p1: framebuffer address issue ----
  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET) begin
      row_base    <= '0;
      col         <= '0;
      bus.rd_addr <= '0;
      bus.rd_en   <= 1'b0;
    end else begin
      bus.rd_en <= vld_p0;
      if (sof_p0) begin
        row_base <= '0;
        col      <= '0;
      end else if (vld_p0) begin
        bus.rd_addr <= row_base + 16'(col);
        if (last_col_p0) begin
          col <= '0;
          if (row_step_p0) row_base <= row_base + 16'(FB_W);
        end else if (col_step_p0) begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // ---- p1..pLAT: flag delay line; RGB captured as read data lands ----
  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET) begin
      hs_sr     <= '1;
      vs_sr     <= '1;
      sof_sr    <= '0;
      act_sr    <= '0;
      vld_sr    <= '0;
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
    end else begin
      hs_sr[1]  <= hs_p0;
      vs_sr[1]  <= vs_p0;
      sof_sr[1] <= sof_p0;
      act_sr[1] <= act_p0;
      vld_sr[1] <= vld_p0;
      for (int i = 2; i <= LAT; i++) begin
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        sof_sr[i] <= sof_sr[i-1];
      end
      for (int i = 2; i < LAT; i++) begin
        act_sr[i] <= act_sr[i-1];
        vld_sr[i] <= vld_sr[i-1];
      end
      if (vld_sr[LAT-1] && act_sr[LAT-1]) begin
        bus.vga_r <= bus.rd_data[11:8];
        bus.vga_g <= bus.rd_data[7:4];
        bus.vga_b <= bus.rd_data[3:0];
      end else begin
        bus.vga_r <= '0;
        bus.vga_g <= '0;
        bus.vga_b <= '0;
      end
    end
  end

  assign bus.hsync       = hs_sr[LAT];
  assign bus.vsync       = vs_sr[LAT];
  assign bus.frame_start = sof_sr[LAT];

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Reader side of the 300x200 waveform framebuffer. The drawing logic fills the framebuffer through the write port (row*300+col addressing, 12-bit colour in a 16-bit word).
- This block drives the read port: it generates 640x480@60 VGA timing on DCLK (25 MHz pixel clock), fetches framebuffer words in raster order and outputs 4:4:4 RGB plus syncs.
- The framebuffer image sits in a fixed window; everything outside the window is black.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- FB_W, 300, framebuffer columns
- FB_H, 200, framebuffer rows
- X_OFF, 20, window left edge (screen x)
- Y_OFF, 40, window top edge (screen y)
- RD_LAT, 2, framebuffer read latency in cycles, address to data

Ports:
- DCLK  in  1  pixel clock
- RESET  in  1  asynchronous, active-low reset
- rd_addr  out  16  framebuffer read address
- rd_en  out  1  read enable
- rd_data  in  16  framebuffer word; bits [11:8]=R, [7:4]=G, [3:0]=B, [15:12] ignored
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- frame_start  out  1  one-cycle pulse with pixel (0,0)

Behaviour:
- Counters:
  - h_cnt counts 0..H_total-1, H_total=800. v_cnt counts 0..V_total-1, V_total=525.
  - v_cnt increments when h_cnt wraps; both wrap to 0 together at (799,524).
- Window:
  - 1x: x in [X_OFF, X_OFF+FB_W), y in [Y_OFF, Y_OFF+FB_H).
- Addressing:
  - No multiplier. A row_base register is cleared at frame start and gains FB_W after each completed framebuffer row.
  - A col counter increments per framebuffer pixel and clears at the window's right edge.
  - Address = row_base + col.
- Read pipeline:
  - Counters at cycle t. rd_addr/rd_en are registered and valid at t+1. rd_data is valid at t+1+RD_LAT. RGB is registered at t+2+RD_LAT.
  - Total latency LAT = RD_LAT+2.
  - hsync, vsync, active and in-window flags go through an LAT-deep shift register so all outputs stay aligned.
- Syncs:
  - hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
  - vsync low for v_cnt in [490,492).
  - Both are seen at the outputs LAT cycles later.
- RGB:
  - In window: rd_data fields.
  - Active but outside window: 0.
  - Blanking: 0.
- rd_en:
  - High only for in-window pixels.
  - Outside the window, rd_addr holds its last value.
- Boundaries:
  - Last address FB_W*FB_H-1 = 59999 at window (299,199).
  - After the last window pixel, row_base/col reload to 0 at the next frame start; no address ever exceeds 59999.
- frame_start:
  - High exactly one cycle, in the same cycle the output RGB corresponds to screen (0,0).
- Reset:
  - Counters, row_base, col and the pipeline clear immediately. Pipeline sync bits reset to 1 and flags to 0.
  - Output reset values: hsync=1, vsync=1, vga_r/g/b=0, rd_en=0, rd_addr=0, frame_start=0.
  - On release, h_cnt=0, v_cnt=0 on the first edge. First frame_start occurs LAT cycles later.
  - Reset mid-frame aborts the frame with no partial-address carry-over.
- rd_data is not sampled when the delayed in-window flag is 0.

Optional Feature:
- Macro: SCALE2X_EN.
- Defined:
  - Window becomes 2*FB_W x 2*FB_H (600x400) at (X_OFF,Y_OFF).
  - Each framebuffer pixel is repeated on 2 consecutive columns; col advances every second in-window cycle.
  - Each framebuffer row is repeated on 2 consecutive lines; row_base advances after every second window line.
  - Address range and latency are unchanged.
- Not defined: 1x window as above; no scaling logic is synthesized.

Test Plan:
- Reset and sync timing:
  - Stimulus: hold RESET low for 10 cycles, then release.
  - Response: outputs at reset values during reset. hsync period 800 cycles, low 96 cycles; first falling edge at cycle 656+LAT after release. vsync period 420000 cycles, low 1600 cycles.
- 1x window pixels (memory model returns rd_data=address, RD_LAT=2):
  - Screen (20,40) -> address 0, RGB 0x000.
  - Screen (21,40) -> address 1, RGB 0x001.
  - Screen (20,41) -> address 300, RGB 0x12C.
  - Screen (319,239) -> address 59999, RGB 0xA5F.
- Border and blanking:
  - Screen (19,40), (320,40), (100,39) -> RGB 0, rd_en low for the corresponding cycles.
  - rd_en high exactly 60000 cycles per frame.
- frame_start:
  - Exactly one pulse per 420000 cycles.
  - Aligned with the output of screen (0,0) and the start of the hsync/vsync frame sequence.
- Reset mid-frame:
  - Stimulus: assert RESET at v_cnt=100, h_cnt=300; release 5 cycles later.
  - Response: rd_addr=0 during reset. The next window pixel fetched is address 0 at screen (20,40) of the new frame.
- SCALE2X_EN build:
  - Screen (20,40) and (21,41) -> address 0.
  - Screen (22,40) -> address 1.
  - Screen (20,42) -> address 300.
  - Screen (619,439) -> address 59999.
  - rd_en high 240000 cycles per frame.
